// File: rtl/vending_if.sv
// Handshake bundle between the coin/selection front end and vending_ctrl.
//   master : drives moneyin_pulse, select, return_req; observes controller outputs
//   slave  : the controller side (vending_ctrl)
// Signals:
//   moneyin_pulse[3:0] one-cycle coin pulses, bit i = coin channel i
//   select[3:0]        product request pulses, bit i = product i
//   return_req         refund request for all remaining credit
//   credit             current credit (registered)
//   dispense[3:0]      one-hot one-cycle dispense strobe
//   change_out[3:0]    one-hot one-cycle coin-eject strobe
//   coin_reject[3:0]   echo of rejected coin bits
//   deny               selection refused strobe
//   busy               controller not idle
interface vending_if #(
  parameter int unsigned CREDIT_W = 14
);
  logic [3:0]          moneyin_pulse;
  logic [3:0]          select;
  logic                return_req;
  logic [CREDIT_W-1:0] credit;
  logic [3:0]          dispense;
  logic [3:0]          change_out;
  logic [3:0]          coin_reject;
  logic                deny;
  logic                busy;

  modport master (
    output moneyin_pulse, select, return_req,
    input  credit, dispense, change_out, coin_reject, deny, busy
  );

  modport slave (
    input  moneyin_pulse, select, return_req,
    output credit, dispense, change_out, coin_reject, deny, busy
  );
endinterface

// File: rtl/vending_ctrl.sv
// Vending machine sequencer: accumulates coin credit, services product
// selections and pays out change one coin per cycle.
// Ports:
//   clk   : system clock, all state on rising edge
//   reset : synchronous active-high reset, clears all state
//   bus   : vending_if.slave (coins/select/return in, credit and strobes out)
// Optional build macro:
//   AUTO_CHANGE_EN : after a dispense, automatically refund any remaining
//                    credit; when undefined, credit is kept for further buys.
module vending_ctrl #(
  parameter int unsigned CREDIT_W   = 14,
  parameter int unsigned MAX_CREDIT = 10000,
  parameter int unsigned COIN0_VAL  = 100,
  parameter int unsigned COIN1_VAL  = 500,
  parameter int unsigned COIN2_VAL  = 1000,
  parameter int unsigned COIN3_VAL  = 5000,
  parameter int unsigned PRICE0     = 300,
  parameter int unsigned PRICE1     = 500,
  parameter int unsigned PRICE2     = 700,
  parameter int unsigned PRICE3     = 1200
) (
  input logic     clk,
  input logic     reset,
  vending_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2
  } state_t;

  localparam logic [CREDIT_W:0] MAX_EXT = MAX_CREDIT[CREDIT_W:0];

  function automatic logic [CREDIT_W:0] coin_val(input logic [1:0] i);
    case (i)
      2'd0:    coin_val = COIN0_VAL[CREDIT_W:0];
      2'd1:    coin_val = COIN1_VAL[CREDIT_W:0];
      2'd2:    coin_val = COIN2_VAL[CREDIT_W:0];
      default: coin_val = COIN3_VAL[CREDIT_W:0];
    endcase
  endfunction

  function automatic logic [CREDIT_W:0] price(input logic [1:0] i);
    case (i)
      2'd0:    price = PRICE0[CREDIT_W:0];
      2'd1:    price = PRICE1[CREDIT_W:0];
      2'd2:    price = PRICE2[CREDIT_W:0];
      default: price = PRICE3[CREDIT_W:0];
    endcase
  endfunction

  state_t              state;
  logic [CREDIT_W-1:0] credit_q;
  logic [3:0]          dispense_q;
  logic [3:0]          change_q;
  logic [3:0]          reject_q;
  logic                deny_q;
  logic                busy_q;

  logic [CREDIT_W:0]   credit_ext;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W:0]   coin_total;
  logic [1:0]          sel_idx;
  logic                sel_found;
  logic [CREDIT_W:0]   sel_price;
  logic [1:0]          chg_idx;
  logic [CREDIT_W:0]   chg_val;

  always_comb begin
    credit_ext = {1'b0, credit_q};
    coin_sum   = '0;
    sel_idx    = 2'd0;
    sel_found  = 1'b0;
    chg_idx    = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bus.moneyin_pulse[i])
        coin_sum = coin_sum + coin_val(i[1:0]);
      // lowest set select bit wins
      if (bus.select[i] && !sel_found) begin
        sel_idx   = i[1:0];
        sel_found = 1'b1;
      end
      // ascending scan leaves the largest coin that still fits
      if (coin_val(i[1:0]) <= credit_ext)
        chg_idx = i[1:0];
    end
    coin_total = credit_ext + coin_sum;
    sel_price  = price(sel_idx);
    chg_val    = coin_val(chg_idx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      credit_q   <= '0;
      dispense_q <= '0;
      change_q   <= '0;
      reject_q   <= '0;
      deny_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      dispense_q <= '0;
      change_q   <= '0;
      reject_q   <= '0;
      deny_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.return_req) begin
            reject_q <= bus.moneyin_pulse;
            if (credit_q != '0) begin
              state  <= CHANGE;
              busy_q <= 1'b1;
            end
          end else if (bus.select != '0) begin
            reject_q <= bus.moneyin_pulse;
            if (credit_ext >= sel_price) begin
              credit_q   <= credit_q - sel_price[CREDIT_W-1:0];
              dispense_q <= 4'b0001 << sel_idx;
              state      <= DISPENSE;
              busy_q     <= 1'b1;
            end else begin
              deny_q <= 1'b1;
            end
          end else if (bus.moneyin_pulse != '0) begin
            // all-or-nothing: a cycle's coins are either all accepted or all rejected
            if (coin_total <= MAX_EXT)
              credit_q <= coin_total[CREDIT_W-1:0];
            else
              reject_q <= bus.moneyin_pulse;
          end
        end
        DISPENSE: begin
          reject_q <= bus.moneyin_pulse;
`ifdef AUTO_CHANGE_EN
          if (credit_q != '0) begin
            state  <= CHANGE;
            busy_q <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
`else
          state  <= IDLE;
          busy_q <= 1'b0;
`endif
        end
        CHANGE: begin
          reject_q <= bus.moneyin_pulse;
          if (chg_val <= credit_ext) begin
            change_q <= 4'b0001 << chg_idx;
            credit_q <= credit_q - chg_val[CREDIT_W-1:0];
          end
          if (chg_val >= credit_ext) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            busy_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.credit      = credit_q;
  assign bus.dispense    = dispense_q;
  assign bus.change_out  = change_q;
  assign bus.coin_reject = reject_q;
  assign bus.deny        = deny_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Self-checking bench for vending_ctrl: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// behavioural model of credit, pending refund and dispense in progress.
module tb_vending_ctrl;
  localparam int MAXC     = 10000;
  localparam int COINV[4] = '{100, 500, 1000, 5000};
  localparam int PRICE[4] = '{300, 500, 700, 1200};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vending_if #(.CREDIT_W(14)) bus ();

  vending_ctrl #(.CREDIT_W(14)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  int m_credit   = 0;
  bit m_refund   = 0;   // refund in progress
  bit m_disp     = 0;   // dispense cycle in progress
  int e_disp, e_chg, e_rej, e_deny, e_busy;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [3:0] mp, input logic [3:0] sel,
                            input logic rr, input logic rst);
    int k;
    int sum;
    e_disp = 0; e_chg = 0; e_rej = 0; e_deny = 0;
    if (rst) begin
      m_credit = 0; m_refund = 0; m_disp = 0;
    end else if (m_refund) begin
      e_rej = mp;
      for (int i = 3; i >= 0; i--) begin
        if (e_chg == 0 && COINV[i] <= m_credit) begin
          e_chg    = 1 << i;
          m_credit = m_credit - COINV[i];
        end
      end
      if (m_credit == 0) m_refund = 0;
    end else if (m_disp) begin
      e_rej  = mp;
      m_disp = 0;
`ifdef AUTO_CHANGE_EN
      if (m_credit > 0) m_refund = 1;
`endif
    end else if (rr) begin
      e_rej = mp;
      if (m_credit > 0) m_refund = 1;
    end else if (sel != 0) begin
      e_rej = mp;
      k = 0;
      while (!sel[k]) k++;
      if (m_credit >= PRICE[k]) begin
        m_credit = m_credit - PRICE[k];
        e_disp   = 1 << k;
        m_disp   = 1;
      end else begin
        e_deny = 1;
      end
    end else begin
      sum = 0;
      for (int i = 0; i < 4; i++) if (mp[i]) sum += COINV[i];
      if (m_credit + sum <= MAXC) m_credit = m_credit + sum;
      else e_rej = mp;
    end
    e_busy = (m_refund || m_disp) ? 1 : 0;
  endtask

  // one clock: apply inputs, step model at the edge, compare 1 time unit later
  task automatic cycle(input logic [3:0] mp, input logic [3:0] sel,
                       input logic rr, input logic rst);
    reset             = rst;
    bus.moneyin_pulse = mp;
    bus.select        = sel;
    bus.return_req    = rr;
    @(posedge clk);
    model_step(mp, sel, rr, rst);
    #1;
    chk("credit",      int'(bus.credit),      m_credit);
    chk("dispense",    int'(bus.dispense),    e_disp);
    chk("change_out",  int'(bus.change_out),  e_chg);
    chk("coin_reject", int'(bus.coin_reject), e_rej);
    chk("deny",        int'(bus.deny),        e_deny);
    chk("busy",        int'(bus.busy),        e_busy);
    chk("credit_max",  (int'(bus.credit) <= MAXC) ? 1 : 0, 1);
  endtask

  task automatic idle();
    cycle(4'b0000, 4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] mp, sel;
    logic rr, rst;

    reset = 1'b1;
    bus.moneyin_pulse = '0;
    bus.select = '0;
    bus.return_req = 1'b0;

    // reset state
    cycle(4'b0000, 4'b0000, 1'b0, 1'b1);
    chk("lit_reset_credit", int'(bus.credit), 0);
    chk("lit_reset_busy",   int'(bus.busy),   0);

    // coins: 500 then 600
    cycle(4'b0010, 4'b0000, 1'b0, 1'b0);
    chk("lit_credit_500", int'(bus.credit), 500);
    idle();
    cycle(4'b0001, 4'b0000, 1'b0, 1'b0);
    chk("lit_credit_600", int'(bus.credit), 600);
    chk("lit_no_reject",  int'(bus.coin_reject), 0);

    // purchase product 0 at 600
    cycle(4'b0000, 4'b0001, 1'b0, 1'b0);
    chk("lit_dispense0",   int'(bus.dispense), 1);
    chk("lit_credit_300",  int'(bus.credit),   300);
    chk("lit_busy_disp",   int'(bus.busy),     1);
    idle();
`ifdef AUTO_CHANGE_EN
    chk("lit_busy_to_chg", int'(bus.busy), 1);
    idle();
    chk("lit_auto_chg_200", int'(bus.credit), 200);
    chk("lit_auto_chg_out", int'(bus.change_out), 1);
    idle();
    idle();
    chk("lit_auto_chg_0",   int'(bus.credit), 0);
    chk("lit_auto_busy0",   int'(bus.busy), 0);
`else
    chk("lit_busy_after",  int'(bus.busy),   0);
    chk("lit_keep_300",    int'(bus.credit), 300);
`endif

    // deny at credit 200
    cycle(4'b0000, 4'b0000, 1'b0, 1'b1);
    cycle(4'b0001, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0001, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 4'b0100, 1'b0, 1'b0);
    chk("lit_deny",        int'(bus.deny),     1);
    chk("lit_deny_credit", int'(bus.credit),   200);
    chk("lit_deny_nodisp", int'(bus.dispense), 0);
    idle();
    chk("lit_deny_pulse",  int'(bus.deny),     0);
    cycle(4'b0000, 4'b0110, 1'b0, 1'b0);
    chk("lit_deny_multi",  int'(bus.deny),     1);

    // credit ceiling at 9600
    cycle(4'b0000, 4'b0000, 1'b0, 1'b1);
    cycle(4'b1100, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(4'b0100, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0011, 4'b0000, 1'b0, 1'b0);
    chk("lit_credit_9600", int'(bus.credit), 9600);
    cycle(4'b0011, 4'b0000, 1'b0, 1'b0);
    chk("lit_reject_0011", int'(bus.coin_reject), 3);
    chk("lit_hold_9600",   int'(bus.credit), 9600);
    cycle(4'b0001, 4'b0000, 1'b0, 1'b0);
    chk("lit_credit_9700", int'(bus.credit), 9700);

    // refund of 6600 with a coin during the payout
    cycle(4'b0000, 4'b0000, 1'b0, 1'b1);
    cycle(4'b1111, 4'b0000, 1'b0, 1'b0);
    chk("lit_credit_6600", int'(bus.credit), 6600);
    cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
    chk("lit_ret_busy",    int'(bus.busy), 1);
    chk("lit_ret_nochg",   int'(bus.change_out), 0);
    cycle(4'b0001, 4'b0000, 1'b0, 1'b0);
    chk("lit_chg_1000",    int'(bus.change_out), 8);
    chk("lit_chg_rej",     int'(bus.coin_reject), 1);
    chk("lit_chg_c1600",   int'(bus.credit), 1600);
    idle();
    chk("lit_chg_0100",    int'(bus.change_out), 4);
    idle();
    chk("lit_chg_0010",    int'(bus.change_out), 2);
    idle();
    chk("lit_chg_0001",    int'(bus.change_out), 1);
    chk("lit_chg_c0",      int'(bus.credit), 0);
    chk("lit_chg_busy0",   int'(bus.busy), 0);

    // reset during refund of 1100
    cycle(4'b0101, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
    idle();
    chk("lit_mid_busy",    int'(bus.busy), 1);
    cycle(4'b0000, 4'b0000, 1'b0, 1'b1);
    chk("lit_rst_credit",  int'(bus.credit), 0);
    chk("lit_rst_chg",     int'(bus.change_out), 0);
    chk("lit_rst_busy",    int'(bus.busy), 0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      mp  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      sel = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      rr  = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 499) == 0);
      cycle(mp, sel, rr, rst);
    end

    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
